// File: rtl/and_chain_pkg.sv
// Shared defaults, legal limits and counter sizing for the AND-chain channel array.
package and_chain_pkg;

    localparam int unsigned DEF_NUM_CH = 5;
    localparam int unsigned DEF_WINDOW = 4;
    localparam int unsigned DEF_CHAIN  = 1;

    localparam int unsigned MAX_NUM_CH = 32;
    localparam int unsigned MAX_WINDOW = 255;

    // Counter must be able to hold the value WINDOW itself (saturation point).
    function automatic int unsigned cnt_width(input int unsigned window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/and_chain_array_if.sv
// Per-channel operand/flag bundle between a driver and the AND-chain array.
interface and_chain_array_if
    import and_chain_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH
);
    logic [NUM_CH-1:0] a;
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] c;
    logic [NUM_CH-1:0] d;
    logic [NUM_CH-1:0] e;
    logic [NUM_CH-1:0] f;
    logic              all_f;

    modport master (output a, b, c, input d, e, f, all_f);
    modport slave  (input a, b, c, output d, e, f, all_f);
endinterface

// File: rtl/and_chain_cell.sv
// One channel: registered a&b, saturating run counter of a&b&c, and the window flag.
module and_chain_cell
    import and_chain_pkg::*;
#(
    parameter int unsigned WINDOW = DEF_WINDOW
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e
);

    localparam int unsigned CNT_W = cnt_width(WINDOW);
    localparam int unsigned INC_W = CNT_W + 1;

    logic             hit;
    logic [CNT_W-1:0] cnt;
    logic [INC_W-1:0] cnt_inc;

    assign hit     = a & b & c;
    assign cnt_inc = {1'b0, cnt} + INC_W'(1);

    // cnt+1 >= WINDOW is the same test as cnt >= WINDOW-1, without an underflow at WINDOW=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            d   <= 1'b0;
            e   <= 1'b0;
            cnt <= '0;
        end else begin
            d <= a & b;
            if (hit) begin
                if (cnt_inc <= INC_W'(WINDOW)) begin
                    cnt <= cnt_inc[CNT_W-1:0];
                end
                e <= (cnt_inc >= INC_W'(WINDOW));
            end else begin
                cnt <= '0;
                e   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/and_chain_array.sv
// Array of independent AND-window channels with a registered qualification chain and all_f.
module and_chain_array
    import and_chain_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned CHAIN  = DEF_CHAIN
) (
    input logic              clk,
    input logic              rst,
    and_chain_array_if.slave bus
);

    if (NUM_CH == 0 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
        $error("and_chain_array: NUM_CH out of range");
    end
    if (WINDOW == 0 || WINDOW > MAX_WINDOW) begin : g_bad_window
        $error("and_chain_array: WINDOW out of range");
    end
    if (CHAIN > 1) begin : g_bad_chain
        $error("and_chain_array: CHAIN must be 0 or 1");
    end

    logic [NUM_CH-1:0] d_q;
    logic [NUM_CH-1:0] e_q;
    logic [NUM_CH-1:0] f_q;
    logic [NUM_CH-1:0] f_nxt;
    logic              all_f_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cell
        and_chain_cell #(
            .WINDOW (WINDOW)
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .a   (bus.a[i]),
            .b   (bus.b[i]),
            .c   (bus.c[i]),
            .d   (d_q[i]),
            .e   (e_q[i])
        );
    end

    // In chain mode each stage qualifies on the previous stage's registered f.
    always_comb begin
        f_nxt = e_q;
        if (CHAIN != 0) begin
            for (int unsigned i = 1; i < NUM_CH; i++) begin
                f_nxt[i] = e_q[i] & f_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q     <= '0;
            all_f_q <= 1'b0;
        end else begin
            f_q     <= f_nxt;
            all_f_q <= &e_q;
        end
    end

    assign bus.d     = d_q;
    assign bus.e     = e_q;
    assign bus.f     = f_q;
    assign bus.all_f = all_f_q;

endmodule

// File: tb/tb_and_chain_array.sv
// Bench for and_chain_array: directed scenarios plus random traffic against a run-length model.
module tb_and_chain_array;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 4;
    localparam int unsigned HL = N + 2;

    logic clk;
    logic rst1;
    logic rst2;

    int checks = 0;
    int errors = 0;

    and_chain_array_if #(.NUM_CH(N)) bus1 ();
    and_chain_array_if #(.NUM_CH(N)) bus2 ();

    and_chain_array #(.NUM_CH(N), .WINDOW(W), .CHAIN(1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    and_chain_array #(.NUM_CH(N), .WINDOW(1), .CHAIN(0)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model for dut1: run length of consecutive true cycles and history of e.
    int         run [N];
    logic [N-1:0] d_m, e_m, f_m;
    logic         allf_m;
    logic [N-1:0] eh [$];
    // Model for dut2: history of sampled a&b&c.
    logic [N-1:0] h2 [$];
    logic [N-1:0] e2_m, f2_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [N-1:0] abc;
        logic [N-1:0] tmp;
        logic         fi;
        if (rst1) begin
            foreach (run[i]) run[i] = 0;
            d_m = '0; e_m = '0; f_m = '0; allf_m = 1'b0;
            eh.delete();
            repeat (HL) eh.push_back('0);
        end else begin
            abc    = bus1.a & bus1.b & bus1.c;
            allf_m = &e_m;
            d_m    = bus1.a & bus1.b;
            for (int i = 0; i < N; i++) begin
                run[i] = abc[i] ? run[i] + 1 : 0;
                e_m[i] = (run[i] >= W);
            end
            eh.push_front(e_m);
            void'(eh.pop_back());
            // f[i] is e[j] from (i-j+1) edges ago, ANDed over all j <= i.
            for (int i = 0; i < N; i++) begin
                fi = 1'b1;
                for (int j = 0; j <= i; j++) begin
                    tmp = eh[1 + i - j];
                    fi  = fi & tmp[j];
                end
                f_m[i] = fi;
            end
        end
        if (rst2) begin
            h2.delete();
            h2.push_back('0);
            h2.push_back('0);
        end else begin
            h2.push_front(bus2.a & bus2.b & bus2.c);
            void'(h2.pop_back());
        end
        e2_m = h2[0];
        f2_m = h2[1];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        check("d1", 32'(bus1.d), 32'(d_m));
        check("e1", 32'(bus1.e), 32'(e_m));
        check("f1", 32'(bus1.f), 32'(f_m));
        check("all_f1", 32'(bus1.all_f), 32'(allf_m));
        check("e2", 32'(bus2.e), 32'(e2_m));
        check("f2", 32'(bus2.f), 32'(f2_m));
    endtask

    // Mostly-true channels so that windows complete often.
    task automatic rand_in(output logic [N-1:0] ra, output logic [N-1:0] rb, output logic [N-1:0] rc);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(7, 0) != 0) begin
                ra[i] = 1'b1; rb[i] = 1'b1; rc[i] = 1'b1;
            end else begin
                ra[i] = 1'($urandom); rb[i] = 1'($urandom); rc[i] = 1'($urandom);
            end
        end
    endtask

    task automatic rand2();
        logic [N-1:0] ra, rb, rc;
        rand_in(ra, rb, rc);
        bus2.a = ra; bus2.b = rb; bus2.c = rc;
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        rand2();
        step();
        rst1 = 1'b0;
    endtask

    initial begin
        logic [N-1:0] ra, rb, rc;
        eh.delete();
        repeat (HL) eh.push_back('0);
        h2.push_back('0);
        h2.push_back('0);
        foreach (run[i]) run[i] = 0;
        e_m = '0;

        // Reset overrides all-ones inputs.
        rst1 = 1'b1; rst2 = 1'b1;
        bus1.a = '1; bus1.b = '1; bus1.c = '1;
        bus2.a = '1; bus2.b = '1; bus2.c = '1;
        repeat (3) begin
            step();
            check("rst_dfa", 32'({bus1.d, bus1.e, bus1.f, bus1.all_f}), 32'(0));
        end
        rst2 = 1'b0;

        // Latency on ch0 and window on ch2.
        rst1 = 1'b0;
        bus1.a = 5'b00101; bus1.b = 5'b00101; bus1.c = 5'b00100;
        rand2(); step();
        check("lat_d0_rise", 32'(bus1.d[0]), 32'(1));
        rand2(); step();
        rand2(); step();
        check("win_e2_early", 32'(bus1.e[2]), 32'(0));
        bus1.a = 5'b00100;
        rand2(); step();
        check("lat_d0_fall", 32'(bus1.d[0]), 32'(0));
        check("win_e2_rise", 32'(bus1.e[2]), 32'(1));

        // Break at edge 2 restarts the window.
        reset1();
        bus1.a = 5'b00100; bus1.b = 5'b00100; bus1.c = 5'b00100;
        rand2(); step();
        rand2(); step();
        bus1.c = 5'b00000;
        rand2(); step();
        bus1.c = 5'b00100;
        for (int k = 3; k <= 6; k++) begin
            rand2(); step();
            if (k == 5) check("win2_e2_early", 32'(bus1.e[2]), 32'(0));
        end
        check("win2_e2_rise", 32'(bus1.e[2]), 32'(1));

        // Chain ripple and all_f.
        reset1();
        bus1.a = '1; bus1.b = '1; bus1.c = '1;
        for (int k = 0; k <= 9; k++) begin
            rand2(); step();
            if (k == 2) check("chain_e_early", 32'(bus1.e), 32'(0));
            if (k == 3) begin
                check("chain_e_full", 32'(bus1.e), 32'h1F);
                check("chain_f_none", 32'(bus1.f), 32'(0));
            end
            if (k == 4) begin
                check("chain_f0", 32'(bus1.f), 32'h01);
                check("chain_all_f", 32'(bus1.all_f), 32'(1));
            end
            if (k == 8) check("chain_f_full", 32'(bus1.f), 32'h1F);
        end
        bus1.c = 5'b11011;
        rand2(); step();
        bus1.c = '1;
        rand2(); step();
        check("brk_f_11", 32'(bus1.f), 32'h1B);
        rand2(); step();
        check("brk_f_12", 32'(bus1.f), 32'h13);
        rand2(); step();
        check("brk_f_13", 32'(bus1.f), 32'h03);

        // Reset mid-run discards a partial count on ch1.
        reset1();
        bus1.a = 5'b00010; bus1.b = 5'b00010; bus1.c = 5'b00010;
        repeat (3) begin rand2(); step(); end
        rst1 = 1'b1;
        rand2(); step();
        rst1 = 1'b0;
        repeat (3) begin rand2(); step(); end
        check("mid_rst_e1_early", 32'(bus1.e[1]), 32'(0));
        rand2(); step();
        check("mid_rst_e1_rise", 32'(bus1.e[1]), 32'(1));

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            rand_in(ra, rb, rc);
            bus1.a = ra; bus1.b = rb; bus1.c = rc;
            rst1 = ($urandom_range(49, 0) == 0);
            rst2 = ($urandom_range(49, 0) == 0);
            rand2();
            step();
        end
        rst1 = 1'b0; rst2 = 1'b0;

        // Long saturation hold on both instances.
        bus1.a = '1; bus1.b = '1; bus1.c = '1;
        bus2.a = '1; bus2.b = '1; bus2.c = '1;
        repeat (300) step();
        check("hold_e2", 32'(bus2.e), 32'h1F);
        check("hold_f2", 32'(bus2.f), 32'h1F);
        check("hold_f1", 32'(bus1.f), 32'h1F);

        for (int k = 0; k < 100; k++) begin
            rand_in(ra, rb, rc);
            bus1.a = ra; bus1.b = rb; bus1.c = rc;
            rand2();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
